// File: rtl/step_ctrl_pkg.sv
// Shared types and sizing helpers for the step clock controller.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        S_STEP = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } step_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int RUN_DIV_DEF         = 25_000_000;
    localparam int CNT_W_DEF           = 16;

    // Bits needed for a counter running 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchronizer plus stability counter for an active-low pushbutton.
// Emits the debounced level and a one-cycle press strobe on its falling edge.
module btn_debouncer
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic btn_db,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt_d = cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            db_q      <= 1'b1;
            db_prev_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync2_q == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                db_q  <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign btn_db = db_q;
    assign press  = db_prev_q & ~db_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// Core clock-enable generator: single steps from a debounced button, periodic
// steps in run mode, all gated by the core's halt output.
module step_clock_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int RUN_DIV         = RUN_DIV_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_n,
    input  logic             run_sw,
    input  logic             halt,
    output logic             step_en,
    output logic [CNT_W-1:0] step_count,
    output logic             btn_db,
    output logic             mode_run
);

    localparam int DIV_W = cnt_width(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ARM  = DIV_W'(RUN_DIV - 2);

    logic             press;
    logic             sw_sync1_q;
    logic             sw_sync2_q;
    step_state_t      state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             step_en_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debouncer (
        .clk    (clk),
        .reset  (reset),
        .btn_n  (btn_n),
        .btn_db (btn_db),
        .press  (press)
    );

    // halt kills a pulse in the very cycle it is raised, hence the gate after the register.
    assign step_en = step_en_q & ~halt;
    assign count_d = count_q + CNT_W'(step_en);
    assign div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_sync1_q <= 1'b0;
            sw_sync2_q <= 1'b0;
            state_q    <= S_STEP;
            div_q      <= '0;
            step_en_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            sw_sync1_q <= run_sw;
            sw_sync2_q <= sw_sync1_q;
            count_q    <= count_d;
            step_en_q  <= 1'b0;
            if (halt) begin
                state_q <= S_HALT;
                div_q   <= '0;
            end else begin
                unique case (state_q)
                    S_HALT: begin
                        state_q <= sw_sync2_q ? S_RUN : S_STEP;
                        div_q   <= '0;
                    end
                    S_STEP: begin
                        // A mode change swallows a coincident press.
                        if (sw_sync2_q) begin
                            state_q <= S_RUN;
                            div_q   <= '0;
                        end else begin
                            step_en_q <= press;
                        end
                    end
                    S_RUN: begin
                        if (!sw_sync2_q) begin
                            state_q <= S_STEP;
                            div_q   <= '0;
                        end else begin
                            div_q     <= div_d;
                            step_en_q <= (div_q == DIV_ARM);
                        end
                    end
                    default: begin
                        state_q <= S_STEP;
                        div_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign step_count = count_q;
    assign mode_run   = (state_q == S_RUN);

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Randomized and directed bench for step_clock_ctrl against a behavioural model.
module tb_step_clock_ctrl;

    localparam int DEB  = 4;
    localparam int RDIV = 5;
    localparam int CW   = 4;

    localparam int M_STEP = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          btn_n = 1'b1;
    logic          run_sw = 1'b0;
    logic          halt = 1'b0;
    logic          step_en;
    logic [CW-1:0] step_count;
    logic          btn_db;
    logic          mode_run;

    always #5 clk = ~clk;

    step_clock_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .RUN_DIV         (RDIV),
        .CNT_W           (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn_n),
        .run_sw     (run_sw),
        .halt       (halt),
        .step_en    (step_en),
        .step_count (step_count),
        .btn_db     (btn_db),
        .mode_run   (mode_run)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: raw inputs reach logic two clocks late; the button level
    // flips only after DEB consecutive synchronized samples disagree with it; run
    // pulses land every RDIV cycles counted from the first cycle spent in run mode.
    int m_state;
    int m_age;
    int m_count;
    bit m_pend;
    bit m_db;
    bit m_press;
    bit bq[$];
    bit sq[$];
    bit win[$];

    function automatic void model_reset();
        m_state = M_STEP;
        m_age   = 0;
        m_count = 0;
        m_pend  = 1'b0;
        m_db    = 1'b1;
        m_press = 1'b0;
        bq      = '{1'b1, 1'b1};
        sq      = '{1'b0, 1'b0};
        win.delete();
    endfunction

    function automatic void model_update();
        bit sb;
        bit ss;
        bit press_now;
        bit all_diff;
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_pend && !halt) m_count = (m_count + 1) % (1 << CW);
        sb = bq.pop_front();
        bq.push_back(btn_n);
        ss = sq.pop_front();
        sq.push_back(run_sw);
        press_now = m_press;
        m_press   = 1'b0;
        win.push_back(sb);
        if (win.size() > DEB) void'(win.pop_front());
        all_diff = (win.size() == DEB);
        foreach (win[i]) if (win[i] == m_db) all_diff = 1'b0;
        if (all_diff) begin
            m_db = ~m_db;
            win.delete();
            if (!m_db) m_press = 1'b1;
        end
        m_pend = 1'b0;
        if (halt) begin
            m_state = M_HALT;
        end else if (m_state == M_HALT) begin
            m_state = ss ? M_RUN : M_STEP;
            m_age   = 0;
        end else if (m_state == M_STEP) begin
            if (ss) begin
                m_state = M_RUN;
                m_age   = 0;
            end else begin
                m_pend = press_now;
            end
        end else begin
            if (!ss) begin
                m_state = M_STEP;
            end else begin
                m_age++;
                m_pend = ((m_age % RDIV) == RDIV - 1);
            end
        end
    endfunction

    bit chk_on = 1'b0;
    int cyc = 0;
    int n_pulses = 0;
    int pulse_cyc = -1;
    bit pulse_now = 1'b0;
    int db_low_cnt = 0;

    task automatic cycle();
        cyc++;
        @(negedge clk);
        if (chk_on) begin
            chk("step_en", {31'd0, step_en}, {31'd0, (m_pend && !halt)});
            chk("step_count", {28'd0, step_count}, m_count);
            chk("btn_db", {31'd0, btn_db}, {31'd0, m_db});
            chk("mode_run", {31'd0, mode_run}, (m_state == M_RUN) ? 1 : 0);
        end
        pulse_now = (step_en === 1'b1);
        if (pulse_now) begin
            n_pulses++;
            pulse_cyc = cyc;
        end
        if (btn_db === 1'b0) db_low_cnt++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        int prev;
        int rel;
        int k;
        int btn_left;
        int sw_left;
        int halt_left;

        // 1. Reset held with the button pressed and run selected
        reset  = 1'b0;
        btn_n  = 1'b0;
        run_sw = 1'b1;
        halt   = 1'b0;
        model_reset();
        cycle();
        chk_on = 1'b1;
        cycle();
        cycle();
        chk("reset_step_en", {31'd0, step_en}, 0);
        chk("reset_count", {28'd0, step_count}, 0);
        chk("reset_btn_db", {31'd0, btn_db}, 1);
        chk("reset_mode_run", {31'd0, mode_run}, 0);
        reset  = 1'b1;
        btn_n  = 1'b1;
        run_sw = 1'b0;
        repeat (6) cycle();

        // 2. Clean press in step mode
        n_pulses = 0;
        btn_n = 1'b0;
        repeat (10) cycle();
        btn_n = 1'b1;
        repeat (12) cycle();
        chk("step_pulses", n_pulses, 1);
        chk("step_count_1", {28'd0, step_count}, 1);
        chk("step_btn_rel", {31'd0, btn_db}, 1);

        // 3. Bouncing button never gets accepted
        n_pulses   = 0;
        db_low_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            btn_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            cycle();
        end
        btn_n = 1'b1;
        repeat (8) cycle();
        chk("bounce_db_low", db_low_cnt, 0);
        chk("bounce_pulses", n_pulses, 0);
        chk("bounce_count", {28'd0, step_count}, 1);

        // 4. Run mode: evenly spaced pulses and counter wrap
        run_sw   = 1'b1;
        n_pulses = 0;
        prev     = -1;
        for (int i = 0; i < 200 && n_pulses < 16; i++) begin
            cycle();
            if (pulse_now) begin
                if (prev >= 0) chk("run_gap", cyc - prev, RDIV);
                prev = cyc;
            end
        end
        chk("run_pulses", n_pulses, 16);
        chk("run_wrap_count", {28'd0, step_count}, 1);
        chk("run_mode", {31'd0, mode_run}, 1);

        // 5. Halt raised on a would-be pulse cycle
        for (int i = 0; i < 20 && !m_pend; i++) cycle();
        chk("halt_armed", {31'd0, m_pend}, 1);
        halt     = 1'b1;
        n_pulses = 0;
        repeat (12) cycle();
        chk("halt_pulses", n_pulses, 0);
        chk("halt_count", {28'd0, step_count}, 1);
        halt     = 1'b0;
        rel      = cyc + 1;
        n_pulses = 0;
        for (int i = 0; i < 20 && n_pulses == 0; i++) cycle();
        chk("halt_resume_gap", (n_pulses > 0) ? (pulse_cyc - rel) : -1, RDIV);

        // 6. Reset in the middle of a run-mode count
        for (int i = 0; i < 20 && !(m_state == M_RUN && (m_age % RDIV) == 3); i++) cycle();
        chk("mid_div_at_3", {31'd0, (m_state == M_RUN && (m_age % RDIV) == 3)}, 1);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("mid_reset_count", {28'd0, step_count}, 0);
        chk("mid_reset_mode", {31'd0, mode_run}, 0);
        chk("mid_reset_step_en", {31'd0, step_en}, 0);
        k = 0;
        for (int i = 0; i < 10 && mode_run !== 1'b1; i++) begin
            cycle();
            k++;
        end
        chk("rerun_latency", k, 3);

        // 7. Randomized traffic against the model
        btn_left  = 0;
        sw_left   = 0;
        halt_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (btn_left == 0) begin
                btn_n    = $urandom_range(0, 1);
                btn_left = $urandom_range(1, 12);
            end
            btn_left--;
            if (sw_left == 0) begin
                run_sw  = $urandom_range(0, 1);
                sw_left = $urandom_range(20, 150);
            end
            sw_left--;
            if (halt_left > 0) begin
                halt_left--;
                halt = (halt_left > 0);
            end else if ($urandom_range(0, 29) == 0) begin
                halt      = 1'b1;
                halt_left = $urandom_range(1, 8);
            end
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
